// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_arbiter
// Description : OAM DMA engine (FF46 trigger) and CPU/DMA arbiter for the
//               memory bus. Define DMA_CPU_BLOCK_EN to block CPU non-HRAM
//               accesses while DMA is active; otherwise the CPU steals cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_arbiter #(
   parameter int PERIOD  = 4,
   parameter int DMA_LEN = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_din,
   output logic [15:0] mem_a,
   output logic [7:0]  mem_dout,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [7:0]  mem_din,
   output logic        dma_active,
   output logic        dma_done
);

   localparam int        PW       = $clog2(PERIOD + 1);
   localparam int        GAP_LOAD = (PERIOD > 3) ? PERIOD - 4 : 0;
   localparam logic [7:0] LAST    = 8'(DMA_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_R1    = 3'd2,
      S_R2    = 3'd3,
      S_W     = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t          state_q;
   logic [7:0]      dma_reg_q;
   logic [7:0]      src_hi_q;
   logic [7:0]      byte_cnt_q;
   logic [7:0]      buf_q;
   logic [PW-1:0]   per_cnt_q;
   logic            cpu_wr_q;
   logic            dma_active_q;
   logic            dma_done_q;

   logic w_ff46;
   logic w_hram;
   logic w_req;
   logic w_blocked;
   logic w_steal;
   logic w_ff46_wr;

   assign w_ff46    = (cpu_a == 16'hFF46);
   assign w_hram    = (cpu_a >= 16'hFF80) && (cpu_a <= 16'hFFFE);
   assign w_req     = (cpu_rd | cpu_wr) & ~w_ff46;
   assign w_ff46_wr = cpu_wr & ~cpu_wr_q & w_ff46;

`ifdef DMA_CPU_BLOCK_EN
   assign w_blocked = dma_active_q & ~w_hram & ~w_ff46;
   assign w_steal   = w_req & w_hram;
`else
   assign w_blocked = 1'b0;
   assign w_steal   = w_req;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         dma_reg_q    <= 8'h00;
         src_hi_q     <= 8'h00;
         byte_cnt_q   <= 8'h00;
         buf_q        <= 8'h00;
         per_cnt_q    <= '0;
         cpu_wr_q     <= 1'b0;
         dma_active_q <= 1'b0;
         dma_done_q   <= 1'b0;
      end else begin
         cpu_wr_q   <= cpu_wr;
         dma_done_q <= 1'b0;
         if (w_ff46_wr) begin
            // Any FF46 write (re)starts the transfer from byte 0; E0-FF fold onto echo RAM.
            dma_reg_q    <= cpu_dout;
            src_hi_q     <= (cpu_dout >= 8'hE0) ? cpu_dout - 8'h20 : cpu_dout;
            byte_cnt_q   <= 8'h00;
            per_cnt_q    <= PW'(PERIOD - 1);
            state_q      <= S_START;
            dma_active_q <= 1'b1;
         end else begin
            case (state_q)
               S_START: begin
                  if (!w_steal) begin
                     if (per_cnt_q == '0) state_q <= S_R1;
                     else                 per_cnt_q <= per_cnt_q - 1'b1;
                  end
               end
               S_R1: begin
                  if (!w_steal) state_q <= S_R2;
               end
               S_R2: begin
                  if (w_steal) begin
                     state_q <= S_R1;
                  end else begin
                     buf_q   <= mem_din;
                     state_q <= S_W;
                  end
               end
               S_W: begin
                  if (w_steal) begin
                     state_q <= S_R1;
                  end else if (byte_cnt_q == LAST) begin
                     state_q      <= S_IDLE;
                     dma_active_q <= 1'b0;
                     dma_done_q   <= 1'b1;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 8'd1;
                     per_cnt_q  <= PW'(GAP_LOAD);
                     state_q    <= (PERIOD == 3) ? S_R1 : S_GAP;
                  end
               end
               S_GAP: begin
                  if (!w_steal) begin
                     if (per_cnt_q == '0) state_q <= S_R1;
                     else                 per_cnt_q <= per_cnt_q - 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   // A forwarded CPU access always wins the bus for that clock.
   always_comb begin
      mem_a    = cpu_a;
      mem_dout = cpu_dout;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      if (w_req && !w_blocked) begin
         mem_rd = cpu_rd & ~cpu_wr;
         mem_wr = cpu_wr;
      end else begin
         case (state_q)
            S_R1, S_R2: begin
               mem_a  = {src_hi_q, byte_cnt_q};
               mem_rd = 1'b1;
            end
            S_W: begin
               mem_a    = 16'hFE00 + {8'h00, byte_cnt_q};
               mem_dout = buf_q;
               mem_wr   = 1'b1;
            end
            default: ;
         endcase
      end
      if (rst) begin
         mem_rd = 1'b0;
         mem_wr = 1'b0;
      end
   end

   always_comb begin
      if (w_ff46)         cpu_din = dma_reg_q;
      else if (w_blocked) cpu_din = 8'hFF;
      else                cpu_din = mem_din;
   end

   assign dma_active = dma_active_q;
   assign dma_done   = dma_done_q;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_arbiter.sv
`default_nettype none
// Bench for oam_dma_arbiter: memory model, scoreboard of expected OAM writes,
// one task per scenario.
module tb_oam_dma_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cpu_a = 16'h0000;
   logic [7:0]  cpu_dout = 8'h00;
   logic        cpu_rd = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_din;
   logic [15:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        dma_active;
   logic        dma_done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int rd10_cnt = 0;
   int d000_wr = 0;
   logic [23:0] sb[$];

   always #5 clk = ~clk;

   function automatic logic [7:0] fn(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
   endfunction

   assign mem_din = fn(mem_a);

   oam_dma_arbiter #(.PERIOD(4), .DMA_LEN(160)) dut (
      .clk(clk), .rst(rst),
      .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_din(cpu_din),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_din(mem_din),
      .dma_active(dma_active), .dma_done(dma_done)
   );

   // Monitor: pops the scoreboard on every OAM write.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (mem_rd && mem_wr) begin
            errors++;
            $display("FAIL strobe_excl: mem_rd=%b mem_wr=%b, required not both high", mem_rd, mem_wr);
         end
         if (dma_done) done_cnt++;
         if (mem_rd && mem_a == 16'hC10A) rd10_cnt++;
         if (mem_wr && mem_a == 16'hD000) d000_wr++;
         if (mem_wr && mem_a >= 16'hFE00 && mem_a < 16'hFEA0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL oam_write: unexpected write a=%h d=%h, required none", mem_a, mem_dout);
            end else begin
               logic [23:0] e;
               e = sb.pop_front();
               if ({mem_a, mem_dout} !== e) begin
                  errors++;
                  $display("FAIL oam_write: got a=%h d=%h, required a=%h d=%h",
                           mem_a, mem_dout, e[23:8], e[7:0]);
               end
            end
         end
      end
   end

   task automatic start_dma(input logic [7:0] v);
      logic [7:0] s;
      s = (v >= 8'hE0) ? v - 8'h20 : v;
      @(posedge clk);
      sb.delete();
      for (int i = 0; i < 160; i++) sb.push_back({16'hFE00 + 16'(i), fn({s, 8'(i)})});
      #1;
      cpu_a = 16'hFF46; cpu_dout = v; cpu_wr = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_wr !== 1'b0) begin
         errors++;
         $display("FAIL ff46_not_fwd: mem_wr=%b, required 0", mem_wr);
      end
      @(posedge clk); #1;
      cpu_wr = 1'b0; cpu_a = 16'h0000;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dma_done && n < 3000);
      if (n >= 3000) begin
         errors++;
         $display("FAIL done_timeout: no dma_done after %0d clocks, required one", n);
      end
   endtask

   task automatic wait_sb_le(input int lim);
      int t;
      t = 0;
      while (sb.size() > lim && t < 2000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 2000) begin
         errors++;
         $display("FAIL sb_wait: queue=%0d, required <=%0d", sb.size(), lim);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cpu_a = 16'hFF46; cpu_rd = 1'b1;
      @(negedge clk);
      checks++;
      if (dma_active !== 1'b0 || dma_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: active=%b done=%b, required 0 0", dma_active, dma_done);
      end
      checks++;
      if (cpu_din !== 8'h00 || mem_rd !== 1'b0) begin
         errors++;
         $display("FAIL reset_ff46: din=%h mem_rd=%b, required 00 0", cpu_din, mem_rd);
      end
      @(posedge clk); #1;
      cpu_rd = 1'b0; cpu_a = 16'h0000;
   endtask

   task automatic test_single_transfer();
      int n;
      start_dma(8'hC1);
      checks++;
      if (dma_active !== 1'b1) begin
         errors++;
         $display("FAIL active_rise: dma_active=%b, required 1", dma_active);
      end
      wait_done(n);
      checks++;
      if (n != 644) begin
         errors++;
         $display("FAIL done_latency: got %0d clocks, required 644", n);
      end
      @(negedge clk);
      checks++;
      if (sb.size() != 0 || dma_active !== 1'b0 || dma_done !== 1'b0) begin
         errors++;
         $display("FAIL single_end: left=%0d active=%b done=%b, required 0 0 0",
                  sb.size(), dma_active, dma_done);
      end
   endtask

   task automatic test_echo_fold();
      int n;
      start_dma(8'hE3);
      wait_done(n);
      @(posedge clk); #1;
      cpu_a = 16'hFF46; cpu_rd = 1'b1;
      @(negedge clk);
      checks++;
      if (cpu_din !== 8'hE3 || mem_rd !== 1'b0) begin
         errors++;
         $display("FAIL ff46_readback: din=%h mem_rd=%b, required E3 0", cpu_din, mem_rd);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL echo_left: %0d writes missing, required 0", sb.size());
      end
      @(posedge clk); #1;
      cpu_rd = 1'b0; cpu_a = 16'h0000;
   endtask

   task automatic test_cpu_access();
      int n;
      logic [7:0] exp_rd;
      int exp_wr;
`ifdef DMA_CPU_BLOCK_EN
      exp_rd = 8'hFF; exp_wr = 0;
`else
      exp_rd = fn(16'hC000); exp_wr = 1;
`endif
      d000_wr = 0;
      start_dma(8'hC1);
      wait_sb_le(140);
      #1 cpu_a = 16'hC000; cpu_rd = 1'b1;
      @(negedge clk);
      checks++;
      if (cpu_din !== exp_rd) begin
         errors++;
         $display("FAIL cpu_rd_c000: din=%h, required %h", cpu_din, exp_rd);
      end
      @(posedge clk); #1;
      cpu_rd = 1'b0; cpu_a = 16'hD000; cpu_dout = 8'h55; cpu_wr = 1'b1;
      @(posedge clk); #1;
      cpu_wr = 1'b0; cpu_a = 16'hFF90; cpu_rd = 1'b1;
      @(negedge clk);
      checks++;
      if (cpu_din !== fn(16'hFF90)) begin
         errors++;
         $display("FAIL hram_rd: din=%h, required %h", cpu_din, fn(16'hFF90));
      end
      @(posedge clk); #1;
      cpu_rd = 1'b0; cpu_a = 16'h0000;
      wait_done(n);
      checks++;
      if (d000_wr != exp_wr || sb.size() != 0) begin
         errors++;
         $display("FAIL cpu_wr_d000: writes=%0d left=%0d, required %0d 0", d000_wr, sb.size(), exp_wr);
      end
   endtask

   task automatic test_hram_stall();
      int n;
      int t;
      rd10_cnt = 0;
      start_dma(8'hC1);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(mem_rd && mem_a == 16'hC10A) && t < 2000);
      @(posedge clk); #1;
      cpu_a = 16'hFF90; cpu_dout = 8'h77; cpu_wr = 1'b1;
      #1;
      checks++;
      if (mem_a !== 16'hFF90 || mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_dout !== 8'h77) begin
         errors++;
         $display("FAIL hram_take: a=%h wr=%b rd=%b d=%h, required ff90 1 0 77",
                  mem_a, mem_wr, mem_rd, mem_dout);
      end
      @(posedge clk); #1;
      cpu_wr = 1'b0; cpu_a = 16'h0000;
      wait_done(n);
      checks++;
      if (rd10_cnt != 3 || sb.size() != 0) begin
         errors++;
         $display("FAIL byte10_reread: reads=%0d left=%0d, required 3 0", rd10_cnt, sb.size());
      end
   endtask

   task automatic test_restart();
      int n;
      int d0;
      start_dma(8'hC1);
      wait_sb_le(110);
      d0 = done_cnt;
      start_dma(8'hC2);
      wait_done(n);
      checks++;
      if (n != 644) begin
         errors++;
         $display("FAIL restart_latency: got %0d clocks, required 644", n);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (done_cnt - d0 != 1 || sb.size() != 0) begin
         errors++;
         $display("FAIL restart_done: pulses=%0d left=%0d, required 1 0", done_cnt - d0, sb.size());
      end
   endtask

   task automatic test_rst_mid();
      int n;
      int d0;
      start_dma(8'hC1);
      wait_sb_le(80);
      d0 = done_cnt;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (dma_active !== 1'b0 || dma_done !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: active=%b done=%b rd=%b wr=%b, required 0 0 0 0",
                  dma_active, dma_done, mem_rd, mem_wr);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (700) @(negedge clk);
      checks++;
      if (done_cnt != d0 || sb.size() != 80) begin
         errors++;
         $display("FAIL rst_quiet: pulses=%0d left=%0d, required 0 80", done_cnt - d0, sb.size());
      end
      start_dma(8'hC1);
      wait_done(n);
      checks++;
      if (n != 644) begin
         errors++;
         $display("FAIL rst_rerun_latency: got %0d clocks, required 644", n);
      end
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL rst_rerun_left: %0d writes missing, required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_transfer();
      test_echo_fold();
      test_cpu_access();
      test_hram_stall();
      test_restart();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
